// File: rtl/line_clear.sv
// rtl/line_clear.sv - Full-row clearing and board compaction engine
//
// Scans the board bottom-up one row per cycle. A full row is removed by
// shifting every row above it down by one and filling row 0 with zeros; the
// same row index is then re-examined so stacked full rows are all cleared.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      one-cycle request, accepted only while idle
//   board_in   board to process, cell (r,c) = bit r*COLS+c, row 0 on top
//   busy       high while a pass is running (SCAN/SHIFT/DONE)
//   done       one-cycle pulse at the end of a pass
//   board_out  compacted board, held until the next accepted start
//   lines      number of rows cleared by the last pass
//   score      (LINE_CLEAR_SCORE_EN only) saturating accumulated score
//
// Optional feature macro: LINE_CLEAR_SCORE_EN adds the score output.

module line_clear #(
  parameter int COLS = 10,
  parameter int ROWS = 20
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [0:COLS*ROWS-1] board_in,
  output logic                 busy,
  output logic                 done,
  output logic [0:COLS*ROWS-1] board_out,
  output logic [4:0]           lines
`ifdef LINE_CLEAR_SCORE_EN
  ,
  output logic [15:0]          score
`endif
);

  localparam int N  = COLS * ROWS;
  localparam int PW = (ROWS > 1) ? $clog2(ROWS) : 1;

  typedef enum logic [1:0] {IDLE, SCAN, SHIFT, DONE} state_t;

  state_t          state, state_nxt;
  logic [0:N-1]    work;
  logic [0:N-1]    shifted;
  logic [PW-1:0]   ptr;
  logic [4:0]      cnt;
  logic            row_full;

  // Full-row detect on the row selected by the pointer.
  always_comb begin
    row_full = 1'b0;
    for (int r = 0; r < ROWS; r++) begin
      if (ptr == PW'(r)) row_full = &work[r*COLS +: COLS];
    end
  end

  // Rows 0..ptr-1 drop by one; rows below the pointer are untouched.
  always_comb begin
    shifted = work;
    for (int r = 1; r < ROWS; r++) begin
      if (PW'(r) <= ptr) shifted[r*COLS +: COLS] = work[(r-1)*COLS +: COLS];
    end
    shifted[0 +: COLS] = '0;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (start) state_nxt = SCAN;
      SCAN:  begin
        if (row_full)           state_nxt = SHIFT;
        else if (ptr == '0)     state_nxt = DONE;
      end
      SHIFT: state_nxt = SCAN;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = (state != IDLE);
    done = (state == DONE);
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      work  <= '0;
      ptr   <= PW'(ROWS - 1);
      cnt   <= '0;
      lines <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          work <= board_in;
          cnt  <= '0;
          ptr  <= PW'(ROWS - 1);
        end
        SCAN: if (!row_full && ptr != '0) ptr <= ptr - 1'b1;
        SHIFT: begin
          work <= shifted;
          cnt  <= cnt + 5'd1;
        end
        DONE: lines <= cnt;
        default: ;
      endcase
    end
  end

  assign board_out = work;

`ifdef LINE_CLEAR_SCORE_EN
  logic [15:0] points;
  logic [16:0] score_sum;

  always_comb begin
    case (cnt)
      5'd0:    points = 16'd0;
      5'd1:    points = 16'd1;
      5'd2:    points = 16'd3;
      5'd3:    points = 16'd5;
      default: points = 16'd8;
    endcase
    score_sum = {1'b0, score} + {1'b0, points};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)              score <= '0;
    else if (state == DONE)  score <= score_sum[16] ? 16'hFFFF : score_sum[15:0];
  end
`endif

endmodule

// File: tb/tb_line_clear.sv
// tb/tb_line_clear.sv - Self-checking bench for line_clear against a row-list model

module tb_line_clear;

  localparam int COLS = 10;
  localparam int ROWS = 20;
  localparam int N    = COLS * ROWS;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           start;
  logic [0:N-1]   board_in;
  logic           busy;
  logic           done;
  logic [0:N-1]   board_out;
  logic [4:0]     lines;

  int passed = 0;
  int total  = 0;

  line_clear #(.COLS(COLS), .ROWS(ROWS)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .board_in  (board_in),
    .busy      (busy),
    .done      (done),
    .board_out (board_out),
    .lines     (lines)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Model: collect non-full rows bottom-up, restack them at the bottom.
  task automatic model(input logic [0:N-1] b, output logic [0:N-1] o, output int k);
    logic [0:COLS-1] kept[$];
    logic [0:COLS-1] row;
    kept = {};
    k = 0;
    for (int r = ROWS - 1; r >= 0; r--) begin
      row = b[r*COLS +: COLS];
      if (row == {COLS{1'b1}}) k++;
      else kept.push_back(row);
    end
    o = '0;
    for (int i = 0; i < kept.size(); i++) o[(ROWS-1-i)*COLS +: COLS] = kept[i];
  endtask

  function automatic logic [0:N-1] set_row(input logic [0:N-1] b, input int r, input logic [0:COLS-1] v);
    logic [0:N-1] t;
    t = b;
    t[r*COLS +: COLS] = v;
    return t;
  endfunction

  // Called #1 after a rising edge; that next edge samples start (cycle 0).
  task automatic run_pass(input logic [0:N-1] b, input string tag);
    logic [0:N-1] exp_b;
    int k, cyc;
    logic busy_ok;
    model(b, exp_b, k);
    board_in = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 1;
    busy_ok = 1'b1;
    while (!done && cyc < 300) begin
      if (!busy) busy_ok = 1'b0;
      @(posedge clk); #1;
      cyc++;
    end
    check({tag, "_done_cycle"}, N'(cyc), N'(ROWS + 2*k + 1));
    check({tag, "_busy_during"}, N'(busy_ok & busy), N'(1));
    @(posedge clk); #1;
    check({tag, "_done_low"}, N'(done), N'(0));
    check({tag, "_busy_low"}, N'(busy), N'(0));
    check({tag, "_lines"}, N'(lines), N'(k));
    check({tag, "_board"}, board_out, exp_b);
  endtask

  initial begin
    logic [0:N-1] b;
    logic [0:COLS-1] rv;
    int cyc;

    rst_n = 1'b0;
    start = 1'b0;
    board_in = '0;
    #1;
    check("reset_busy", N'(busy), N'(0));
    check("reset_done", N'(done), N'(0));
    check("reset_lines", N'(lines), N'(0));
    check("reset_board", board_out, '0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    run_pass('0, "empty");

    b = '0;
    b = set_row(b, 19, {COLS{1'b1}});
    b = set_row(b, 18, 10'b1000000000);
    run_pass(b, "row19");

    b = '0;
    for (int r = 16; r < 20; r++) b = set_row(b, r, {COLS{1'b1}});
    b = set_row(b, 15, 10'b0101010101);
    run_pass(b, "four");

    b = '0;
    b = set_row(b, 10, {COLS{1'b1}});
    b = set_row(b, 12, {COLS{1'b1}});
    b = set_row(b, 11, 10'b0000000001);
    run_pass(b, "split");

    b = '0;
    b = set_row(b, 0, {COLS{1'b1}});
    b = set_row(b, 5, 10'b0011001100);
    run_pass(b, "top_row");

    run_pass({N{1'b1}}, "all_ones");

    for (int t = 0; t < 8; t++) begin
      b = '0;
      for (int r = 0; r < ROWS; r++) begin
        if ($urandom_range(0, 2) == 0) rv = {COLS{1'b1}};
        else rv = COLS'($urandom);
        b = set_row(b, r, rv);
      end
      run_pass(b, $sformatf("rand%0d", t));
    end

    // Reset in the middle of a SHIFT cycle.
    b = set_row('0, 19, {COLS{1'b1}});
    board_in = b;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("midshift_busy_pre", N'(busy), N'(1));
    rst_n = 1'b0;
    #1;
    check("midshift_busy", N'(busy), N'(0));
    check("midshift_done", N'(done), N'(0));
    check("midshift_lines", N'(lines), N'(0));
    check("midshift_board", board_out, '0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_pass('0, "after_reset");

    // start held high: next pass begins only after DONE.
    board_in = '0;
    start = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    while (!done && cyc < 300) begin @(posedge clk); #1; cyc++; end
    check("held_done_cycle", N'(cyc), N'(21));
    @(posedge clk); #1;
    check("held_idle_gap", N'(busy), N'(0));
    @(posedge clk); #1;
    check("held_restart", N'(busy), N'(1));
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 300) begin @(posedge clk); #1; cyc++; end
    check("held_second_done", N'(cyc), N'(21));

    // start pulse while busy is dropped, not queued.
    @(posedge clk); #1;
    board_in = '0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 6;
    while (!done && cyc < 300) begin @(posedge clk); #1; cyc++; end
    check("noqueue_done_cycle", N'(cyc), N'(21));
    repeat (3) @(posedge clk);
    #1;
    check("noqueue_idle", N'(busy), N'(0));

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
